// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
package br_pkg;

  // funct3 condition codes; 2 and 3 are unused and resolve not-taken.
  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd4,
    BGE  = 3'd5,
    BLTU = 3'd6,
    BGEU = 3'd7
  } branch_cond_e;

  // Result register occupancy: EMPTY, freshly loaded (NEW), or stalled (HELD).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    NEW   = 2'd1,
    HELD  = 2'd2
  } br_state_e;

  // Distance from an instruction to its fall-through / link address.
  localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Branch condition evaluator: purely combinational compare of rs1 and rs2.
module branch_cmp
  import br_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      branch_cond,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            cond
);

  // Select the comparison named by the funct3 code; unused codes give 0.
  always_comb begin
    cond = 1'b0;
    case (branch_cond)
      BEQ:     cond = (operand1 == operand2);
      BNE:     cond = (operand1 != operand2);
      BLT:     cond = ($signed(operand1) <  $signed(operand2));
      BGE:     cond = ($signed(operand1) >= $signed(operand2));
      BLTU:    cond = (operand1 <  operand2);
      BGEU:    cond = (operand1 >= operand2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves branch/jump outcome and target, checks the
// front-end prediction, holds a one-entry result register and pulses a
// fetch redirect once per mispredicted entry.
//
// Handshake: a request transfers on a cycle where in_valid && in_ready; a
// result transfers where out_valid && out_ready. A held result keeps all
// out_* stable until it transfers. flush_in discards the held result and
// blocks acceptance in the same cycle.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [2:0]       branch_cond,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             flush_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_mispredict,
  output logic             out_misaligned,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts,
  output br_state_e        dbg_state
);

  // Low target bits that must be zero for a legal taken target.
  localparam logic [1:0] ALIGN_MASK = (IALIGN == 16) ? 2'b01 : 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic            cond;
  logic            is_cf;
  logic            taken_d;
  logic            misal_d;
  logic            mp_d;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] link_d;
  logic [XLEN-1:0] next_pc_d;
  logic            accept;
  br_state_e       state_q;
  br_state_e       state_d;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .branch_cond (branch_cond),
    .operand1    (operand1),
    .operand2    (operand2),
    .cond        (cond)
  );

  // Resolve outcome, target and prediction check for the incoming request.
  always_comb begin
    jalr_sum  = operand1 + imm;
    target_d  = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
    link_d    = pc + XLEN'(LINK_OFFSET);
    is_cf     = branch | jump | jalr;
    taken_d   = (branch & cond) | jump | jalr;
    next_pc_d = taken_d ? target_d : link_d;
    misal_d   = taken_d & (|(target_d[1:0] & ALIGN_MASK));
    // A misaligned target traps instead of redirecting fetch.
    mp_d      = ((taken_d != pred_taken) | (taken_d & (target_d != pred_target)))
                & ~misal_d;
  end

  assign out_valid      = (state_q != EMPTY);
  assign redirect_valid = (state_q == NEW) & out_mispredict;
  assign redirect_pc    = out_target;
  // Younger ops are squashed during a redirect, so nothing is taken then.
  assign in_ready       = (~out_valid | out_ready) & ~redirect_valid & ~flush_in;
  assign accept         = in_valid & in_ready;
  assign dbg_state      = state_q;

  // Next-state logic for the result register occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = NEW;
      NEW:     if (out_ready) state_d = accept ? NEW : EMPTY;
               else           state_d = HELD;
      HELD:    if (out_ready) state_d = accept ? NEW : EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush_in) state_d = EMPTY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Result register, loaded on every accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_link       <= '0;
      out_mispredict <= 1'b0;
      out_misaligned <= 1'b0;
    end else if (accept) begin
      out_taken      <= taken_d;
      out_target     <= next_pc_d;
      out_link       <= link_d;
      out_mispredict <= mp_d;
      out_misaligned <= misal_d;
    end
  end

  // Saturating statistics, counted as an entry is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (is_cf && stat_branches != CNT_MAX)
        stat_branches <= stat_branches + CNT_W'(1);
      if (mp_d && stat_mispredicts != CNT_MAX)
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised bench for branch_resolve_unit with a queue-based scoreboard.
module tb_branch_resolve_unit;
  import br_pkg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  typedef struct packed {
    logic        br;
    logic        jp;
    logic        jr;
    logic [2:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        pt;
    logic [63:0] ptgt;
  } op_t;

  typedef struct packed {
    logic        taken;
    logic [63:0] nxt;
    logic [63:0] link;
    logic        mp;
    logic        mal;
    logic        cf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             flush_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_link;
  logic             out_mispredict;
  logic             out_misaligned;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
  br_state_e        dbg_state;
  op_t              cur = '0;

  int total = 0;
  int bad   = 0;
  logic rdy_rand   = 1'b0;
  logic flush_rand = 1'b0;

  exp_t exp_q[$];
  exp_t e;
  int   m_br = 0;
  int   m_mp = 0;
  logic first = 1'b1;
  logic exp_in_ready;

  branch_resolve_unit #(.XLEN(XLEN), .IALIGN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .branch(cur.br), .jump(cur.jp), .jalr(cur.jr), .branch_cond(cur.c),
    .operand1(cur.a), .operand2(cur.b), .pc(cur.pc), .imm(cur.imm),
    .pred_taken(cur.pt), .pred_target(cur.ptgt), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_misaligned(out_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input op_t o);
    exp_t r;
    logic cnd;
    longint sa, sb;
    logic [63:0] s, tgt;
    sa = longint'(o.a);
    sb = longint'(o.b);
    case (o.c)
      3'd0:    cnd = (o.a == o.b);
      3'd1:    cnd = (o.a != o.b);
      3'd4:    cnd = (sa < sb);
      3'd5:    cnd = (sa >= sb);
      3'd6:    cnd = (o.a < o.b);
      3'd7:    cnd = (o.a >= o.b);
      default: cnd = 1'b0;
    endcase
    r.cf    = o.br || o.jp || o.jr;
    r.taken = (o.br && cnd) || o.jp || o.jr;
    if (o.jr) begin
      s   = o.a + o.imm;
      tgt = s - (s % 2);
    end else begin
      tgt = o.pc + o.imm;
    end
    r.link  = o.pc + 64'd4;
    r.nxt   = r.taken ? tgt : r.link;
    r.mal   = r.taken && ((tgt % 4) != 0);
    r.mp    = ((r.taken != o.pt) || (r.taken && tgt != o.ptgt)) && !r.mal;
    return r;
  endfunction

  function automatic op_t predict_right(input op_t o);
    exp_t r;
    op_t  p;
    p      = o;
    r      = model(o);
    p.pt   = r.taken;
    p.ptgt = r.nxt;
    return p;
  endfunction

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0:       v = 64'($urandom_range(0, 3));
      1:       v = 64'd0 - 64'($urandom_range(1, 3));
      2:       v = {$urandom, $urandom};
      default: v = 64'h8000_0000_0000_0000;
    endcase
    return v;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  kind;
    o      = '0;
    kind   = $urandom_range(0, 3);
    o.br   = (kind == 1);
    o.jp   = (kind == 2);
    o.jr   = (kind == 3);
    o.c    = 3'($urandom_range(0, 7));
    o.a    = rand_val();
    o.b    = ($urandom_range(0, 2) == 0) ? o.a : rand_val();
    o.pc   = {$urandom, $urandom} & ~64'h3;
    o.imm  = 64'(longint'($urandom_range(0, 511)) - 256);
    if ($urandom_range(0, 1) == 1) o.imm = o.imm & ~64'h3;
    o      = predict_right(o);
    if ($urandom_range(0, 2) == 0) o.pt = ~o.pt;
    if ($urandom_range(0, 3) == 0) o.ptgt = {$urandom, $urandom};
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_taken", out_taken, 0);
    check("rst_target", out_target, 0);
    check("rst_link", out_link, 0);
    check("rst_mispredict", out_mispredict, 0);
    check("rst_misaligned", out_misaligned, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_stat_br", stat_branches, 0);
    check("rst_stat_mp", stat_mispredicts, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, EMPTY);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_br  = 0;
      m_mp  = 0;
      first = 1'b1;
    end else begin
      check("stat_branches", stat_branches, m_br);
      check("stat_mispredicts", stat_mispredicts, m_mp);
      exp_in_ready = ((exp_q.size() == 0) || out_ready)
                     && !((exp_q.size() != 0) && first && exp_q[0].mp)
                     && !flush_in;
      check("in_ready", in_ready, exp_in_ready);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_valid", out_valid, 1);
        check("out_taken", out_taken, e.taken);
        check("out_target", out_target, e.nxt);
        check("out_link", out_link, e.link);
        check("out_mispredict", out_mispredict, e.mp);
        check("out_misaligned", out_misaligned, e.mal);
        check("redirect_valid", redirect_valid, first && e.mp);
        if (first && e.mp) check("redirect_pc", redirect_pc, e.nxt);
      end else begin
        check("out_valid_idle", out_valid, 0);
        check("redirect_idle", redirect_valid, 0);
      end
      if (flush_in) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        first = 1'b1;
      end else if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        first = 1'b1;
      end else if (exp_q.size() != 0) begin
        first = 1'b0;
      end
      if (in_valid && exp_in_ready) begin
        e = model(cur);
        exp_q.push_back(e);
        if (e.cf && m_br < CMAX) m_br++;
        if (e.mp && m_mp < CMAX) m_mp++;
      end
    end
  end

  // Random backpressure and flush when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_rand)   out_ready = ($urandom_range(0, 3) != 0);
    if (flush_rand) flush_in  = ($urandom_range(0, 19) == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input op_t o);
    int   n;
    logic ok;
    n        = 0;
    ok       = 1'b0;
    cur      = o;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      n++;
      tick();
    end while (!ok && n < 100);
    in_valid = 1'b0;
    check("accept_in_time", ok, 1);
  endtask

  function automatic op_t mk(input logic br, input logic jp, input logic jr,
                             input logic [2:0] c, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] pc,
                             input logic [63:0] imm, input logic pt,
                             input logic [63:0] ptgt);
    op_t o;
    o.br = br; o.jp = jp; o.jr = jr; o.c = c; o.a = a; o.b = b;
    o.pc = pc; o.imm = imm; o.pt = pt; o.ptgt = ptgt;
    return o;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();
    tick();

    // Taken BEQ predicted not-taken: mispredict and redirect to 0x1020.
    out_ready = 1'b1;
    drive_op(mk(1, 0, 0, BEQ, 64'd5, 64'd5, 64'h1000, 64'h20, 0, 64'h0));
    repeat (2) tick();

    // Same operands, signed vs unsigned less-than.
    drive_op(mk(1, 0, 0, BLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h3000, 64'h40, 1, 64'h3040));
    drive_op(mk(1, 0, 0, BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h3100, 64'h40, 1, 64'h3140));
    repeat (2) tick();

    // JALR to an odd-halfword target: misaligned, no redirect.
    drive_op(mk(0, 0, 1, 3'd0, 64'h2003, 64'h0, 64'h4000, 64'h0, 1, 64'h2002));
    repeat (2) tick();

    // Mispredicted branch stalled for three cycles.
    out_ready = 1'b0;
    drive_op(mk(1, 0, 0, BNE, 64'd1, 64'd2, 64'h5000, 64'h80, 0, 64'h0));
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (2) tick();

    // Back-to-back correct predictions.
    for (int i = 0; i < 6; i++) begin
      drive_op(predict_right(mk(i[0], ~i[0], 0, BGEU, 64'(i + 1), 64'd1,
                                64'h6000 + 64'(i * 4), 64'h100, 0, 0)));
    end
    repeat (2) tick();

    // Random phase with random backpressure and flushes.
    rdy_rand   = 1'b1;
    flush_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_op(rand_op());
      repeat ($urandom_range(0, 2)) tick();
    end
    rdy_rand   = 1'b0;
    flush_rand = 1'b0;
    tick();
    flush_in   = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();

    // Flush a held result while a new request is presented.
    out_ready = 1'b0;
    drive_op(mk(0, 1, 0, 3'd0, 64'd0, 64'd0, 64'h7000, 64'h10, 1, 64'h7010));
    tick();
    cur      = mk(0, 1, 0, 3'd0, 64'd0, 64'd0, 64'h7100, 64'h10, 0, 64'h0);
    in_valid = 1'b1;
    flush_in = 1'b1;
    tick();
    in_valid = 1'b0;
    flush_in = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_stat_br", stat_branches, m_br);
    tick();

    // Reset asserted for one cycle clears everything.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
